bcd_display_sequencer: RTL and testbench
========================================

# bcd_display_sequencer

Sequential controller for the 4-digit seven-segment display path. It converts an 8-bit switch value to BCD with an iterative shift-add-3 (double-dabble) engine, then commits the result atomically into display registers. It also time-multiplexes the four digits with a programmable refresh prescaler. It drives the anode lines and the 4-bit digit code that feeds the BCD-to-seven-segment decoder, replacing separate slow-clock, counter, decoder and mux glue with one synchronous block.

## Interface
- `REFRESH_DIV`, default 100000: `clk` cycles per digit slot; legal range ≥1.
- `clk`, input, 1 bit: system clock; all state changes on its rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-high.
- `sw`, input, 8 bits: binary value to display, 0–255.
- `busy`, output, 1 bit: high while a conversion is in progress.
- `done`, output, 1 bit: one-cycle pulse when new digits are committed.
- `digit_sel`, output, 2 bits: current scan slot; 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands.
- `an`, output, 4 bits: anodes, active-low; `an[digit_sel]` is low when the slot is lit.
- `digit`, output, 4 bits: BCD code for the current slot, to the segment decoder.

## Operation
- FSM states: IDLE, SHIFT, LOAD.
- **IDLE**
  - If `sw != last_val`: capture `sw` into the shift register, set `last_val <= sw`, clear the BCD accumulator, set `bit_cnt <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT** (one bit per cycle)
  - For each BCD nibble (ones, tens, hundreds): if the nibble is ≥5, add 3.
  - Then shift {hundreds, tens, ones, binary} left by 1.
  - Increment `bit_cnt`; after the 8th SHIFT cycle go to LOAD.
- **LOAD**: copy the accumulator into `disp_ones`, `disp_tens`, `disp_hund`; assert `done`; go to IDLE.
- `busy` = (state != IDLE). `sw` changes during SHIFT or LOAD are ignored. On return to IDLE, `sw` is compared against `last_val` again, so the latest value is always converted eventually.
- Accumulator width is 12 bits. Hundreds never exceeds 2, so no overflow handling is needed.
- Thousands digit is the constant 4'b0000.
- **Scan**
  - `pre_cnt` counts 0..`REFRESH_DIV`-1 and wraps.
  - On wrap, `digit_sel` increments modulo 4 (3 wraps to 0).
  - `an = ~(4'b0001 << digit_sel)`; `digit` = the display register for the slot.
  - Scan runs continuously and independently of the FSM. Display registers change only in LOAD, so the scan never shows a partially converted value.
- **Reset mid-operation**: the conversion is aborted and every register returns to its reset value. No `done` is issued for the aborted conversion.

## Timing
- Reset values: state IDLE, `last_val` 0, display registers 0, `pre_cnt` 0, `digit_sel` 0, `busy` 0, `done` 0, `an` 4'b1110, `digit` 0. Since `last_val` is 0, `sw` = 0 at reset triggers no conversion.
- Conversion latency: with the change detected at edge k (IDLE→SHIFT), SHIFT covers edges k+1..k+8. LOAD commits at edge k+9, when `done` rises and `busy` falls.
  - New `digit` values are visible from the cycle after edge k+9.
  - `busy` is high for exactly 9 cycles.
- Back-to-back: if `sw` differs from `last_val` in the IDLE cycle after LOAD, the next conversion starts at that edge. Minimum spacing between `done` pulses is 10 cycles.
- Slot change: `digit_sel`, `an` and `digit` update together on the edge where `pre_cnt` wraps. With `REFRESH_DIV` = 1 the slot advances every cycle.
- All outputs are registered or decoded from registers only; there is no combinational path from `sw`.

## Configuration
- Macro: `LEADING_ZERO_BLANK_EN`.
- **Defined**: in a blanked slot, `an` is forced to 4'b1111 for the whole slot and `digit_sel` still advances.
  - Thousands is always blanked.
  - Hundreds is blanked when `disp_hund` = 0.
  - Tens is blanked when `disp_hund` = 0 and `disp_tens` = 0.
  - Ones is never blanked.
- **Undefined**: all four slots are always lit; zeros are displayed.

## Test plan
- **Reset**: assert `rst` asynchronously mid-cycle with `sw` = 0 → outputs take the reset values immediately. `busy` stays 0 after release, and `an` = 4'b1110, `digit` = 0.
- **Full-scale conversion**: `sw` = 255 → `busy` high 9 cycles, then `done` pulses once. Slots 0/1/2/3 show `digit` 5/5/2/0.
- **Input change mid-conversion**: `sw` = 100, then `sw` = 37 at the 3rd SHIFT cycle → first `done` commits 0/0/1. The second conversion starts in the following IDLE cycle, and its `done` (10 cycles later) commits 7/3/0.
- **Scan sequence**: `REFRESH_DIV` = 4 → `an` goes 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110. `digit_sel` tracks 0..3.
- **Blanking**: with `LEADING_ZERO_BLANK_EN` defined and `sw` = 7 → `an` = 1110 in slot 0 and 1111 in slots 1–3. With `sw` = 205, slots 0–2 are lit. With the macro undefined, all slots are lit.
- **Reset during SHIFT**: `sw` = 200, then assert `rst` on the 5th SHIFT cycle → no `done` pulse, and display registers stay 0. After release the FSM reconverts (`sw` ≠ 0) and commits 0/0/2.

Source files
------------

// File: rtl/bcd_display_sequencer.sv
// Double-dabble BCD converter with atomic display commit and 4-digit scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero slots.
module bcd_display_sequencer #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    output logic       busy,
    output logic       done,
    output logic [1:0] digit_sel,
    output logic [3:0] an,
    output logic [3:0] digit
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t        state, state_nxt;
    logic [7:0]    last_val, bin_sr;
    logic [11:0]   bcd, bcd_adj;
    logic [3:0]    bit_cnt;
    logic [3:0]    disp_ones, disp_tens, disp_hund;
    logic [PW-1:0] pre_cnt;
    logic          pre_wrap;
    logic          start, shift_en, commit;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift_en  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (sw != last_val) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == 4'd7) state_nxt = LOAD;
            end
            LOAD: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // add-3 correction on every nibble before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++)
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_val  <= 8'd0;
            bin_sr    <= 8'd0;
            bcd       <= 12'd0;
            bit_cnt   <= 4'd0;
            disp_ones <= 4'd0;
            disp_tens <= 4'd0;
            disp_hund <= 4'd0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= commit;
            if (start) begin
                bin_sr   <= sw;
                last_val <= sw;
                bcd      <= 12'd0;
                bit_cnt  <= 4'd0;
            end
            if (shift_en) begin
                {bcd, bin_sr} <= {bcd_adj[10:0], bin_sr, 1'b0};
                bit_cnt       <= bit_cnt + 4'd1;
            end
            if (commit) begin
                disp_ones <= bcd[3:0];
                disp_tens <= bcd[7:4];
                disp_hund <= bcd[11:8];
            end
        end
    end

    assign busy     = (state != IDLE);
    assign pre_wrap = (pre_cnt == PW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt   <= '0;
            digit_sel <= 2'd0;
        end else if (pre_wrap) begin
            pre_cnt   <= '0;
            digit_sel <= digit_sel + 2'd1;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_comb begin
        case (digit_sel)
            2'd0:    digit = disp_ones;
            2'd1:    digit = disp_tens;
            2'd2:    digit = disp_hund;
            default: digit = 4'd0;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lit;
    always_comb begin
        lit[0] = 1'b1;
        lit[1] = (disp_hund != 4'd0) || (disp_tens != 4'd0);
        lit[2] = (disp_hund != 4'd0);
        lit[3] = 1'b0;
        an     = lit[digit_sel] ? ~(4'b0001 << digit_sel) : 4'b1111;
    end
`else
    always_comb begin
        an = ~(4'b0001 << digit_sel);
    end
`endif

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Randomized + directed bench for bcd_display_sequencer against a decimal-arithmetic model.
module tb_bcd_display_sequencer;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sw  = 8'd0;
    logic       busy, done;
    logic [1:0] digit_sel;
    logic [3:0] an, digit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_display_sequencer #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .sw(sw), .busy(busy), .done(done),
        .digit_sel(digit_sel), .an(an), .digit(digit)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dig(input int v, input int s);
        case (s)
            0:       return v % 10;
            1:       return (v / 10) % 10;
            2:       return v / 100;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_an(input int v, input int s);
        bit lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        lit = (s == 0) || (s == 1 && v >= 10) || (s == 2 && v >= 100);
`endif
        return lit ? ((~(1 << s)) & 15) : 15;
    endfunction

    // reference: a conversion is a 9-cycle busy window, then the decimal value appears
    int m_last, m_val, m_cnt, m_disp, m_t;
    bit m_done;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last = 0; m_val = 0; m_cnt = 0; m_disp = 0; m_t = 0; m_done = 0;
        end else begin
            m_t++;
            m_done = 0;
            if (m_cnt == 0) begin
                if (int'(sw) != m_last) begin
                    m_last = sw; m_val = sw; m_cnt = 9;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_disp = m_val; m_done = 1;
                end
            end
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        int s;
        if (chk_en) begin
            s = (m_t / DIV) % 4;
            chk("busy", busy, int'(m_cnt != 0));
            chk("done", done, m_done);
            chk("digit_sel", digit_sel, s);
            chk("an", an, exp_an(m_disp, s));
            chk("digit", digit, dig(m_disp, s));
        end
    end

    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic walk(output int dg[4], output int a[4]);
        repeat (4 * DIV) begin
            @(negedge clk);
            dg[digit_sel] = digit;
            a[digit_sel]  = an;
        end
    endtask

    int n, n2, dones;
    int dg[4], a[4];

    initial begin
        // async reset mid-cycle with sw = 0
        #12 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_an", an, 4'b1110);
        chk("rst_digit", digit, 0);
        chk("rst_sel", digit_sel, 0);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // full scale
        sw = 8'd255;
        wait_done("d255", n);
        chk("lat255", n, 10);
        walk(dg, a);
        chk("d255_s0", dg[0], 5); chk("d255_s1", dg[1], 5);
        chk("d255_s2", dg[2], 2); chk("d255_s3", dg[3], 0);

        // scan order
        chk("scan_s0", a[0], 4'b1110); chk("scan_s1", a[1], 4'b1101);
        chk("scan_s2", a[2], 4'b1011); chk("scan_s3", a[3], 4'b0111);

        // input change during the 3rd SHIFT cycle
        sw = 8'd100;
        repeat (3) @(negedge clk);
        sw = 8'd37;
        wait_done("mid1", n);
        chk("mid1_lat", n, 7);
        chk("mid1_digit", digit, dig(100, digit_sel));
        wait_done("mid2", n2);
        chk("mid_gap", n2, 10);
        walk(dg, a);
        chk("d37_s0", dg[0], 7); chk("d37_s1", dg[1], 3);
        chk("d37_s2", dg[2], 0); chk("d37_s3", dg[3], 0);

        // reset during the 5th SHIFT cycle
        sw = 8'd200;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dones++;
        end
        #2 rst = 1'b1;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_digit", digit, 0);
        chk("rs_an", an, 4'b1110);
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rs_no_done", dones, 0);
        #2 rst = 1'b0;
        wait_done("rs", n);
        chk("rs_lat", n, 10);
        walk(dg, a);
        chk("d200_s0", dg[0], 0); chk("d200_s1", dg[1], 0);
        chk("d200_s2", dg[2], 2); chk("d200_s3", dg[3], 0);

        // leading-zero behaviour
        sw = 8'd7;
        wait_done("d7", n);
        walk(dg, a);
        chk("d7_an0", a[0], 4'b1110);
`ifdef LEADING_ZERO_BLANK_EN
        chk("d7_an1", a[1], 4'b1111); chk("d7_an2", a[2], 4'b1111); chk("d7_an3", a[3], 4'b1111);
`else
        chk("d7_an1", a[1], 4'b1101); chk("d7_an2", a[2], 4'b1011); chk("d7_an3", a[3], 4'b0111);
`endif
        sw = 8'd205;
        wait_done("d205", n);
        walk(dg, a);
        chk("d205_an0", a[0], 4'b1110); chk("d205_an1", a[1], 4'b1101);
        chk("d205_an2", a[2], 4'b1011);
`ifdef LEADING_ZERO_BLANK_EN
        chk("d205_an3", a[3], 4'b1111);
`else
        chk("d205_an3", a[3], 4'b0111);
`endif
        chk("d205_s1", dg[1], 0);

        // random churn, including changes while busy
        repeat (600) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom_range(0, 255));
        end
        repeat (30) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
